fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter IRQ_VEC, default 8'hF0, SHALL be the PC value loaded on interrupt entry.
REQ-002 Parameter FLUSH_CYCLES, default 1, legal range 1..3, SHALL be the number of bubble cycles after any redirect.
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be, in this order:
- clk  in  1  system clock.
- rst  in  1  async active-high reset.
- stall_i  in  1  hazard-unit stall request.
- imm_i  in  1  fetched instruction is two bytes.
- br_taken_i  in  1  EX-stage branch resolved taken.
- br_target_i  in  8  branch destination.
- irq_i  in  1  level interrupt request.
- reti_i  in  1  return-from-interrupt executed.
- pc_i  in  8  current PC value.
- pc_en_o  out  1  PC enable.
- pc_load_o  out  1  PC load target.
- pc_imm_o  out  1  PC advance by 2.
- pc_target_o  out  8  PC load value.
- flush_o  out  1  kill IF/ID contents.
- irq_ack_o  out  1  one-cycle interrupt acknowledge.
- state_o  out  2  FSM state, for debug.

Function
REQ-005 pc_*, flush_o and irq_ack_o SHALL be combinational from the registered state and the current inputs, so the PC acts in the same cycle. State, counter, epc and flags SHALL be registered.
REQ-006 The FSM SHALL have states BOOT=0, RUN=1, FLUSH=2. BOOT lasts exactly one cycle with all outputs 0, then goes to RUN.
REQ-007 In RUN, priority SHALL be: br_taken_i > reti_i > pending interrupt > stall_i > sequential.
REQ-008 Branch in RUN SHALL assert pc_en_o=1, pc_load_o=1, pc_target_o=br_target_i and flush_o=1, then go to FLUSH. This applies even when stall_i=1.
REQ-009 Sequential RUN SHALL drive pc_en_o=~stall_i and pc_imm_o=imm_i&~stall_i. pc_load_o=0.
REQ-010 pc_load_o and pc_imm_o SHALL never be asserted together.
REQ-011 In FLUSH, pc_en_o SHALL be 0 and flush_o SHALL be 1.
- A 2-bit counter loaded with FLUSH_CYCLES-1 on entry returns the FSM to RUN when it reaches 0.
- br_taken_i, reti_i and irq_i are ignored for redirect in FLUSH; irq_i is still latched as pending.
REQ-012 pc_target_o SHALL be 8'h00 whenever pc_load_o=0.

Reset
REQ-013 rst SHALL asynchronously force:
- state=BOOT, counter=0, epc=8'h00, ie=1, pending=0.
- All outputs 0. state_o=0.
REQ-014 Reset asserted in any state, including mid-FLUSH, SHALL abandon the operation with no residual pulse after release.

Configuration
REQ-015 Macro FETCH_SEQ_IRQ_EN, when defined, SHALL compile in interrupt support:
- pending flag set by irq_i&ie.
- Entry in RUN (not stalled, no branch): epc<=pc_i, pc_load_o=1, pc_target_o=IRQ_VEC, flush_o=1, irq_ack_o=1 for one cycle, ie<=0, pending<=0, go to FLUSH.
- reti_i in RUN: pc_load_o=1, pc_target_o=epc, flush_o=1, ie<=1, go to FLUSH.
- A branch and an interrupt in the same cycle: the branch wins and pending is held.
REQ-016 Without FETCH_SEQ_IRQ_EN, irq_i and reti_i SHALL be ignored, irq_ack_o SHALL be tied to 0, and no epc, ie or pending storage SHALL exist.

Structure
REQ-017 The shared package SHALL hold the state encoding constants (BOOT/RUN/FLUSH) and the IRQ_VEC default.
REQ-018 No sub-module is required. The epc/ie/pending logic SHALL be confined to one FETCH_SEQ_IRQ_EN-guarded region.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Release rst, imm_i=0, no stall: cycle 0 all outputs 0 (BOOT); from cycle 1 pc_en_o=1 every cycle and PC counts 0,1,2,3.
- imm_i=1 for one RUN cycle at pc_i=8'h04: pc_imm_o=1, next PC 8'h06.
- stall_i=1 with br_taken_i=1 and br_target_i=8'h40: pc_load_o=1 and flush_o=1; with FLUSH_CYCLES=2, two FLUSH cycles with pc_en_o=0 follow, then RUN at 8'h40.
- FETCH_SEQ_IRQ_EN defined, irq_i=1 at pc_i=8'h12: irq_ack_o pulses once and pc_target_o=8'hF0. A later reti_i reloads 8'h12. A second irq_i before reti_i gets no ack.
- irq_i and br_taken_i (target 8'h30) in the same cycle: load to 8'h30 first; interrupt taken on the first RUN cycle after FLUSH.
- rst asserted mid-FLUSH: outputs go to 0 immediately; after release, exactly one BOOT cycle precedes RUN.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and the default
// interrupt vector.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fsm_state_t;

  localparam logic [7:0] IRQ_VEC_DEFAULT = 8'hF0;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC enable/load/advance and pipeline flush from a
// BOOT/RUN/FLUSH FSM. Interrupt support is compiled in with FETCH_SEQ_IRQ_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [7:0]  IRQ_VEC      = IRQ_VEC_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_i,
  input  logic       imm_i,
  input  logic       br_taken_i,
  input  logic [7:0] br_target_i,
  input  logic       irq_i,
  input  logic       reti_i,
  input  logic [7:0] pc_i,
  output logic       pc_en_o,
  output logic       pc_load_o,
  output logic       pc_imm_o,
  output logic [7:0] pc_target_o,
  output logic       flush_o,
  output logic       irq_ack_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  fsm_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       in_run;
  logic       irq_entry;
  logic       reti_entry;
  logic [7:0] epc_val;

  assign in_run = (state_q == RUN);

`ifdef FETCH_SEQ_IRQ_EN
  logic [7:0] epc_q;
  logic       ie_q;
  logic       pending_q;
  logic       pending_now;

  // A request seen this cycle counts as pending immediately so entry needs no extra cycle.
  assign pending_now = pending_q | (irq_i & ie_q);
  assign reti_entry  = in_run & ~br_taken_i & reti_i;
  assign irq_entry   = in_run & ~br_taken_i & ~reti_i & pending_now & ~stall_i;
  assign epc_val     = epc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q     <= '0;
      ie_q      <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_now & ~irq_entry;
      if (irq_entry) begin
        epc_q <= pc_i;
        ie_q  <= 1'b0;
      end else if (reti_entry) begin
        ie_q  <= 1'b1;
      end
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_i, reti_i, pc_i};
  assign irq_entry  = 1'b0;
  assign reti_entry = 1'b0;
  assign epc_val    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en_o     = 1'b0;
    pc_load_o   = 1'b0;
    pc_imm_o    = 1'b0;
    pc_target_o = '0;
    flush_o     = 1'b0;
    irq_ack_o   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (br_taken_i) begin
          pc_en_o     = 1'b1;
          pc_load_o   = 1'b1;
          pc_target_o = br_target_i;
          flush_o     = 1'b1;
          state_d     = FLUSH;
          cnt_d       = CNT_LOAD;
        end else if (reti_entry) begin
          pc_en_o     = 1'b1;
          pc_load_o   = 1'b1;
          pc_target_o = epc_val;
          flush_o     = 1'b1;
          state_d     = FLUSH;
          cnt_d       = CNT_LOAD;
        end else if (irq_entry) begin
          pc_en_o     = 1'b1;
          pc_load_o   = 1'b1;
          pc_target_o = IRQ_VEC;
          flush_o     = 1'b1;
          irq_ack_o   = 1'b1;
          state_d     = FLUSH;
          cnt_d       = CNT_LOAD;
        end else begin
          pc_en_o  = ~stall_i;
          pc_imm_o = imm_i & ~stall_i;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (cnt_q == 2'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = BOOT;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random traffic,
// compared against a cycle-level behavioural model; IRQ parts follow FETCH_SEQ_IRQ_EN.
module tb_fetch_sequencer;

  localparam int unsigned FC = 2;
`ifdef FETCH_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       stall_i, imm_i, br_taken_i, irq_i, reti_i;
  logic [7:0] br_target_i, pc_i;
  logic       pc_en_o, pc_load_o, pc_imm_o, flush_o, irq_ack_o;
  logic [7:0] pc_target_o;
  logic [1:0] state_o;

  int tests = 0;
  int fails = 0;
  int acks  = 0;

  // Bench-side PC register and reference model state
  logic [7:0] pc;
  bit         m_boot;
  int         m_bub;
  bit         m_pend;
  bit         m_ie;
  logic [7:0] m_epc;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .IRQ_VEC      (8'hF0),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .imm_i       (imm_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .irq_i       (irq_i),
    .reti_i      (reti_i),
    .pc_i        (pc_i),
    .pc_en_o     (pc_en_o),
    .pc_load_o   (pc_load_o),
    .pc_imm_o    (pc_imm_o),
    .pc_target_o (pc_target_o),
    .flush_o     (flush_o),
    .irq_ack_o   (irq_ack_o),
    .state_o     (state_o)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_bub  = 0;
    m_pend = 1'b0;
    m_ie   = 1'b1;
    m_epc  = 8'h00;
    pc     = 8'h00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".en"},    {7'd0, pc_en_o},   8'h00);
    chk({tag, ".load"},  {7'd0, pc_load_o}, 8'h00);
    chk({tag, ".imm"},   {7'd0, pc_imm_o},  8'h00);
    chk({tag, ".tgt"},   pc_target_o,       8'h00);
    chk({tag, ".flush"}, {7'd0, flush_o},   8'h00);
    chk({tag, ".ack"},   {7'd0, irq_ack_o}, 8'h00);
    chk({tag, ".state"}, {6'd0, state_o},   8'h00);
  endtask

  // One clock cycle: drive inputs, predict outputs, compare, advance the PC.
  task automatic cycle(input bit st, input bit im, input bit br, input logic [7:0] tgt,
                       input bit irq, input bit reti);
    bit         e_en, e_ld, e_imm, e_fl, e_ack, pend_now;
    logic [7:0] e_tgt;
    logic [1:0] e_st;
    stall_i = st; imm_i = im; br_taken_i = br; br_target_i = tgt;
    irq_i = irq; reti_i = reti; pc_i = pc;
    @(negedge clk);
    e_en = 0; e_ld = 0; e_imm = 0; e_fl = 0; e_ack = 0; e_tgt = 8'h00;
    pend_now = IRQ_EN && (m_pend || (irq && m_ie));
    if (m_boot) begin
      e_st = 2'd0; m_boot = 0; m_pend = pend_now;
    end else if (m_bub > 0) begin
      e_st = 2'd2; e_fl = 1; m_bub--; m_pend = pend_now;
    end else begin
      e_st = 2'd1;
      if (br) begin
        e_en = 1; e_ld = 1; e_tgt = tgt; e_fl = 1; m_bub = FC; m_pend = pend_now;
      end else if (IRQ_EN && reti) begin
        e_en = 1; e_ld = 1; e_tgt = m_epc; e_fl = 1; m_bub = FC; m_ie = 1; m_pend = pend_now;
      end else if (pend_now && !st) begin
        e_en = 1; e_ld = 1; e_tgt = 8'hF0; e_fl = 1; e_ack = 1; m_bub = FC;
        m_epc = pc; m_ie = 0; m_pend = 0;
      end else begin
        e_en = !st; e_imm = im && !st; m_pend = pend_now;
      end
    end
    chk("pc_en",     {7'd0, pc_en_o},   {7'd0, e_en});
    chk("pc_load",   {7'd0, pc_load_o}, {7'd0, e_ld});
    chk("pc_imm",    {7'd0, pc_imm_o},  {7'd0, e_imm});
    chk("pc_target", pc_target_o,       e_tgt);
    chk("flush",     {7'd0, flush_o},   {7'd0, e_fl});
    chk("irq_ack",   {7'd0, irq_ack_o}, {7'd0, e_ack});
    chk("state",     {6'd0, state_o},   {6'd0, e_st});
    if (irq_ack_o === 1'b1) acks++;
    if (pc_en_o === 1'b1) pc = pc_load_o ? pc_target_o : pc + (pc_imm_o ? 8'd2 : 8'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 0; imm_i = 0; br_taken_i = 0; br_target_i = 8'h00;
    irq_i = 0; reti_i = 0; pc_i = 8'h00;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // BOOT cycle then sequential counting 0,1,2,3
    idle(5);
    chk("pc_count", pc, 8'h04);

    // Two-byte instruction at 0x04
    cycle(0, 1, 0, 8'h00, 0, 0);
    chk("pc_imm_adv", pc, 8'h06);

    // Branch while stalled, FC flush bubbles, resume at target
    cycle(1, 0, 1, 8'h40, 0, 0);
    idle(FC);
    chk("pc_branch", pc, 8'h40);
    idle(1);
    chk("pc_after_branch", pc, 8'h41);

    if (IRQ_EN) begin
      cycle(0, 0, 1, 8'h12, 0, 0);
      idle(FC);
      chk("pc_pre_irq", pc, 8'h12);
      acks = 0;
      cycle(0, 0, 0, 8'h00, 1, 0);
      chk("pc_irq_vec", pc, 8'hF0);
      idle(FC);
      cycle(0, 0, 0, 8'h00, 1, 0);
      idle(2);
      chk("irq_ack_once", acks[7:0], 8'h01);
      cycle(0, 0, 0, 8'h00, 0, 1);
      chk("pc_reti", pc, 8'h12);
      idle(FC);

      // Branch and interrupt together: branch first, interrupt right after flush
      acks = 0;
      cycle(0, 0, 1, 8'h30, 1, 0);
      chk("pc_br_over_irq", pc, 8'h30);
      chk("no_ack_on_branch", acks[7:0], 8'h00);
      idle(FC);
      cycle(0, 0, 0, 8'h00, 0, 0);
      chk("pc_irq_after_flush", pc, 8'hF0);
      chk("ack_after_flush", acks[7:0], 8'h01);
      idle(FC);
      cycle(0, 0, 0, 8'h00, 0, 1);
      chk("pc_reti2", pc, 8'h30);
      idle(FC);
    end

    // Reset during FLUSH
    cycle(0, 0, 1, 8'h80, 0, 0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid_flush");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 8'h00, 0, 0);
    idle(3);
    chk("pc_after_rst", pc, 8'h03);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) == 0, $urandom % 2 == 1, ($urandom % 8) == 0,
            8'($urandom), ($urandom % 10) == 0, ($urandom % 12) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
